// File: rtl/top_pkg.sv
// Shared types and seven-segment code constants for the BCD accumulator display.
package top_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    // Active-low codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Single BCD digit to active-low seven-segment code; non-BCD nibbles show only segment g.
module bcd_to_seg
    import top_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_ERR;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/top.sv
// Four-digit BCD accumulator: adds sw once every TICK_DIV cycles and shows the sum on 7-seg digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units never blanked).
module top
    import top_pkg::*;
#(
    parameter int TICK_DIV = 16
)(
    input  logic        clk,
    input  logic        btn,
    input  logic [7:0]  sw,
    output logic [27:0] display
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_acc;
    logic                  w_tick;
    logic [11:0]           w_sw_bcd;
    logic [15:0]           w_sum;
    logic [NUM_DIGITS-1:0] w_blank;

    // Shift-and-add-3 conversion of an 8-bit binary value into three BCD digits
    function automatic logic [11:0] bin8_to_bcd(input logic [7:0] b);
        logic [19:0] s;
        s = {12'd0, b};
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (s[8+4*k +: 4] >= 4'd5)
                    s[8+4*k +: 4] = s[8+4*k +: 4] + 4'd3;
            end
            s = s << 1;
        end
        return s[19:8];
    endfunction

    function automatic logic [15:0] bcd_add4(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  d;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*k +: 4] = d[3:0];
        end
        return r;
    endfunction

    assign w_tick   = (r_cnt == CNT_MAX);
    assign w_sw_bcd = bin8_to_bcd(sw);
    assign w_sum    = bcd_add4(r_acc, {4'd0, w_sw_bcd});

    always_ff @(posedge clk or posedge btn) begin
        if (btn) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick)
                r_acc <= w_sum;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank    = '0;
        w_blank[3] = (r_acc[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_acc[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_acc[7:4] == 4'd0);
    end
`else
    assign w_blank = '0;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            logic [6:0] w_seg;
            bcd_to_seg u_seg (
                .i_bcd (r_acc[4*g +: 4]),
                .o_seg (w_seg)
            );
            assign display[7*g +: 7] = w_blank[g] ? SEG_BLANK : w_seg;
        end
    endgenerate

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: a decimal model pushes expected display words per tick into a queue.
module tb_top;

    localparam int TD = 16;

    logic        clk;
    logic        btn;
    logic [7:0]  sw;
    logic [27:0] display;

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int acc   = 0;
    logic [27:0] q[$];

    top #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .btn     (btn),
        .sw      (sw),
        .display (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int v);
        logic [27:0] r;
        r = {seg_of((v / 1000) % 10), seg_of((v / 100) % 10), seg_of((v / 10) % 10), seg_of(v % 10)};
`ifdef LEADING_ZERO_BLANK_EN
        if (v < 1000) r[27:21] = 7'b1111111;
        if (v < 100)  r[20:14] = 7'b1111111;
        if (v < 10)   r[13:7]  = 7'b1111111;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % TD;
    endtask

    task automatic step_hold(input string name);
        step();
        total++;
        if (display !== disp(acc)) begin
            bad++;
            $display("FAIL %s: display=%h expected=%h", name, display, disp(acc));
        end
    endtask

    task automatic do_tick(input logic [7:0] s, input string name);
        logic [27:0] e;
        sw = s;
        for (int i = 0; i < TD && phase != TD - 1; i++) step();
        acc = (acc + int'(s)) % 10000;
        q.push_back(disp(acc));
        step();
        e = q.pop_front();
        total++;
        if (display !== e) begin
            bad++;
            $display("FAIL %s: display=%h expected=%h acc=%0d", name, display, e, acc);
        end
    endtask

    task automatic apply_reset(input string name);
        #3;
        btn = 1'b1;
        #1;
        total++;
        if (display !== disp(0)) begin
            bad++;
            $display("FAIL %s: display=%h expected=%h", name, display, disp(0));
        end
        #11;
        btn = 1'b0;
        phase = 0;
        acc = 0;
    endtask

    task automatic test_reset();
        btn = 1'b1;
        sw  = 8'd5;
        #3;
        total++;
        if (display !== disp(0)) begin
            bad++;
            $display("FAIL reset_state: display=%h expected=%h", display, disp(0));
        end
        #47;
        btn = 1'b0;
        phase = 0;
        acc = 0;
        for (int i = 0; i < TD - 1; i++) step_hold("pre_first_tick");
        do_tick(8'd5, "first_tick");
    endtask

    task automatic test_accumulate();
        do_tick(8'd5, "second_tick");
        for (int i = 0; i < 18; i++) do_tick(8'd5, "accum5");
        total++;
        if (display !== disp(100)) begin
            bad++;
            $display("FAIL accum_100: display=%h expected=%h", display, disp(100));
        end
    endtask

    task automatic test_wrap();
        apply_reset("wrap_reset");
        for (int i = 0; i < 38; i++) do_tick(8'd255, "preload255");
        do_tick(8'd210, "preload210");
        total++;
        if (display !== disp(9900)) begin
            bad++;
            $display("FAIL preload_9900: display=%h expected=%h", display, disp(9900));
        end
        do_tick(8'd255, "wrap_9900_255");
        total++;
        if (display !== disp(155)) begin
            bad++;
            $display("FAIL wrap_0155: display=%h expected=%h", display, disp(155));
        end
        for (int i = 0; i < 12; i++) do_tick(8'($urandom_range(0, 255)), "random_add");
        do_tick(8'd99, "add99");
        do_tick(8'd1, "add1");
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) do_tick(8'd0, "zero_tick");
        for (int i = 0; i < 3; i++) begin
            sw = 8'd200;
            step_hold("sw_toggle_200");
            sw = 8'd0;
            step_hold("sw_toggle_0");
            do_tick(8'd0, "toggle_then_zero_tick");
        end
    endtask

    task automatic test_midreset();
        do_tick(8'd123, "pre_midreset");
        for (int i = 0; i < 5; i++) step_hold("midcount");
        apply_reset("midreset_immediate");
        sw = 8'd7;
        for (int i = 0; i < TD - 1; i++) step_hold("post_reset_wait");
        do_tick(8'd7, "resume_tick");
    endtask

    task automatic test_back_to_back();
        do_tick(8'd9, "b2b_9");
        do_tick(8'd91, "b2b_91");
        do_tick(8'd1, "b2b_1");
    endtask

    initial begin
        btn = 1'b1;
        sw  = 8'd0;
        test_reset();
        test_accumulate();
        test_wrap();
        test_hold();
        test_midreset();
        test_back_to_back();
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: time=%0t limit=500000", $time);
        $fatal(1, "timeout");
    end

endmodule
